// File: rtl/rr_packet_selector.sv
// Round-robin or fixed-priority packet arbiter for one crossbar output, held head through tail.
// Latency: the grant is registered, 1 cycle after req in IDLE, and on the same edge as the tail on a release.
// Backpressure: none; the grant is held until a tail flit fires, whatever req does meanwhile.
module rr_packet_selector #(
  parameter int N = 5,
  parameter bit RR_MODE = 1'b1,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          flit_fire,
  input  logic          tail,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] scan_base;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          release_pkt;

  assign release_pkt = (state == LOCKED) && flit_fire && tail;

  // Pointer after a release: one past the channel that just finished, or pinned to 0 in fixed mode.
  always_comb begin
    ptr_next = '0;
    if (RR_MODE) begin
      if (grant_idx == IW'(N - 1)) ptr_next = '0;
      else                         ptr_next = grant_idx + 1'b1;
    end
  end

  // A release arbitrates with the post-release pointer so the handoff needs no extra cycle.
  assign scan_base = (state == LOCKED) ? ptr_next : ptr;

  // Circular scan from scan_base; walking backwards leaves the first requester in scan order as the winner.
  always_comb begin
    logic [IW:0] j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, scan_base} + (IW + 1)'(k);
      if (j >= (IW + 1)'(N)) j = j - (IW + 1)'(N);
      if (req[j[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = j[IW-1:0];
      end
    end
  end

  // Grant lock: take a grant from IDLE, hold it while LOCKED, and hand off or drop it on a tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state       <= LOCKED;
            grant       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
          end
        end
        default: begin
          if (release_pkt) begin
            ptr <= ptr_next;
            if (win_vld) begin
              grant     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
              grant_idx <= win_idx;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_idx   <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_packet_selector.sv
// Bench for rr_packet_selector: one round-robin and one fixed-priority instance share the stimulus.
// Each edge is mirrored by a packet-level model (holder channel plus pointer) and all outputs are compared.
// Directed scenarios come first, followed by a randomized run.
module tb_rr_packet_selector;
  localparam int N  = 5;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic          flit_fire = 1'b0;
  logic          tail = 1'b0;
  logic [N-1:0]  grant_rr, grant_fx;
  logic          gv_rr, gv_fx;
  logic [IW-1:0] idx_rr, idx_fx;

  int total = 0;
  int bad = 0;

  // Model state: the channel holding the output (-1 = nobody) and the priority pointer.
  int hold_rr = -1, ptr_rr = 0;
  int hold_fx = -1, ptr_fx = 0;

  always #5 clk = ~clk;

  rr_packet_selector #(.N(N), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .flit_fire(flit_fire), .tail(tail),
    .grant(grant_rr), .grant_valid(gv_rr), .grant_idx(idx_rr));

  rr_packet_selector #(.N(N), .RR_MODE(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .req(req), .flit_fire(flit_fire), .tail(tail),
    .grant(grant_fx), .grant_valid(gv_fx), .grant_idx(idx_fx));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // The first requester met when walking round the channels from p.
  function automatic int arb(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_edge(input bit rr, inout int hold, inout int ptr);
    if (hold < 0) begin
      hold = arb(req, ptr);
    end else if (flit_fire && tail) begin
      ptr  = rr ? (hold + 1) % N : 0;
      hold = arb(req, ptr);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_rr_grant"}, 32'(grant_rr), hold_rr < 0 ? 0 : 32'(1) << hold_rr);
    chk({tag, "_rr_vld"},   32'(gv_rr),    hold_rr < 0 ? 0 : 1);
    chk({tag, "_rr_idx"},   32'(idx_rr),   hold_rr < 0 ? 0 : hold_rr);
    chk({tag, "_fx_grant"}, 32'(grant_fx), hold_fx < 0 ? 0 : 32'(1) << hold_fx);
    chk({tag, "_fx_vld"},   32'(gv_fx),    hold_fx < 0 ? 0 : 1);
    chk({tag, "_fx_idx"},   32'(idx_fx),   hold_fx < 0 ? 0 : hold_fx);
  endtask

  // Present inputs, clock one edge, update the model with the pre-edge inputs, then compare.
  task automatic step(input logic [N-1:0] r, input logic f, input logic t, input string tag);
    req = r; flit_fire = f; tail = t;
    @(posedge clk);
    model_edge(1'b1, hold_rr, ptr_rr);
    model_edge(1'b0, hold_fx, ptr_fx);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    req = '0; flit_fire = 1'b0; tail = 1'b0;
    #2 rst = 1'b0;
    hold_rr = -1; ptr_rr = 0; hold_fx = -1; ptr_fx = 0;
    #1;
    compare_all("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #3;
    compare_all("por");
    @(negedge clk);
    rst = 1'b1;

    // 1: single request, one-cycle latency, then held after req drops.
    step(5'b00100, 0, 0, "t1a");
    chk("t1_grant", 32'(grant_rr), 32'h04);
    chk("t1_idx", 32'(idx_rr), 2);
    step(5'b00000, 0, 0, "t1b");
    chk("t1_hold", 32'(grant_rr), 32'h04);
    step(5'b00000, 1, 1, "t1c");

    // 2 and 3: all channels request, two-flit packets; RR rotates with no idle gap, fixed stays on ch0.
    do_reset();
    step(5'b11111, 0, 0, "t2s");
    for (int p = 1; p <= 6; p++) begin
      step(5'b11111, 1, 0, "t2m");
      step(5'b11111, 1, 1, "t2t");
      chk("t2_rr_rot", 32'(grant_rr), 32'(1) << (p % N));
      chk("t3_fx_fix", 32'(grant_fx), 32'h01);
    end
    step(5'b11110, 1, 1, "t3b");
    chk("t3_fx_next", 32'(grant_fx), 32'h02);

    // 4: ch3 releases, pointer moves to 4 and wraps to ch0 on the same edge; then idle.
    do_reset();
    step(5'b01000, 0, 0, "t4a");
    step(5'b01001, 1, 1, "t4b");
    chk("t4_handoff", 32'(grant_rr), 32'h01);
    step(5'b00000, 1, 1, "t4c");
    chk("t4_idle", 32'(gv_rr), 0);

    // 5: single-flit packet re-grants the only requester; a fire in IDLE is ignored.
    step(5'b00010, 0, 0, "t5a");
    step(5'b00010, 1, 1, "t5b");
    chk("t5_regrant", 32'(grant_rr), 32'h02);
    step(5'b00000, 1, 1, "t5c");
    step(5'b00000, 1, 1, "t5d");
    chk("t5_idle_fire", 32'(grant_rr), 0);

    // 6: reset mid-packet clears outputs at once and returns the pointer to 0.
    step(5'b00100, 0, 0, "t6a");
    step(5'b01000, 1, 1, "t6b");
    chk("t6_pre", 32'(grant_rr), 32'h08);
    step(5'b01000, 1, 0, "t6c");
    do_reset();
    chk("t6_async", 32'(grant_rr), 0);
    step(5'b11111, 0, 0, "t6d");
    chk("t6_ptr0", 32'(grant_rr), 32'h01);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_packet_selector.md
Name: rr_packet_selector

Overview:
- Parametrised successor to the per-output-port fixed-priority selector in the router crossbar.
- Arbitrates N input-channel requests for one output port and produces a registered one-hot grant.
- Grant is held for a whole wormhole packet, head through tail.
- Supports round-robin or legacy fixed-priority mode; the grant drives the crossbar mux select for that output.

Parameters:
N, 5, number of requesting input channels (N >= 2).
RR_MODE, 1, 1 = round-robin priority rotation; 0 = fixed priority, lowest index wins (legacy behaviour).
IW, $clog2(N), width of grant_idx (derived localparam, not overridable).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
req  input  N  request vector; req[i]=1 means channel i has a flit for this output.
flit_fire  input  1  a flit from the granted channel is transferred downstream this cycle.
tail  input  1  qualifies flit_fire: the transferred flit is a packet tail.
grant  output  N  registered one-hot grant; all zeros when idle.
grant_valid  output  1  registered; 1 when a grant is held (equals |grant).
grant_idx  output  IW  registered binary index of the granted channel; 0 when idle.

Behaviour:
- Reset (rst=0, async): grant=0, grant_valid=0, grant_idx=0, state=IDLE, priority pointer ptr=0.
- States: IDLE, LOCKED.
- Arbitration function arb(req, p):
  - Scan indices p, p+1, ..., N-1, 0, ..., p-1 (mod N).
  - The first set req bit wins; no winner if req=0.
  - RR_MODE=0: p is always 0, so this is pure fixed priority.
- IDLE:
  - req!=0: at next edge, grant/grant_idx load arb(req, ptr), grant_valid=1, go to LOCKED. Latency is exactly 1 cycle from req to grant.
  - req=0: outputs stay 0.
- LOCKED:
  - Grant held unchanged regardless of req changes, including the granted req bit dropping mid-packet (wormhole lock).
  - flit_fire=1 with tail=0: no state change.
  - flit_fire=1 with tail=1 (release):
    - RR_MODE=1: ptr_next=(grant_idx+1) mod N. RR_MODE=0: ptr stays 0.
    - At the same edge, grant loads arb(req, ptr_next) from the current req vector; the releasing channel's req is not masked.
    - If a winner exists, stay LOCKED with the new grant (zero-bubble handoff). If none, go to IDLE with outputs 0.
    - A releasing channel whose req is still high wins again only if no other channel requests (RR) or if it is the lowest index (fixed).
- flit_fire in IDLE: ignored. tail without flit_fire: ignored.
- Single-flit packet: flit_fire=tail=1 in the first LOCKED cycle releases normally.
- ptr updates only on release, never in IDLE.
- Reset asserted mid-packet: immediate clear to reset values; the pointer also returns to 0.
- Invariant: grant is one-hot or zero. grant_valid == |grant. grant_idx encodes grant.
- Wrap-around: grant_idx=N-1 released gives ptr=0.

Test Plan:
1. Reset, then req=5'b00100 for 1 cycle -> next edge grant=00100, grant_idx=2, grant_valid=1. Drop req, no fire -> grant held.
2. N=5, RR_MODE=1, req=11111 constantly; each grant sees 2 fires (tail on the 2nd) -> grants cycle 00001, 00010, 00100, 01000, 10000, 00001 with no idle cycle between packets.
3. RR_MODE=0, req=11111; tail-fire on each packet -> grant always 00001. Then req=11110 -> next grant after release is 00010.
4. Granted ch3 (ptr=3), req=01001, tail-fire -> ptr_next=4, new grant=00001 (idx 0) on the same edge. Then req=0 plus tail-fire -> IDLE, grant=0, grant_valid=0.
5. Fire with tail on the first LOCKED cycle (single-flit packet) while req=00010 alone -> ch1 re-granted immediately. flit_fire pulsed in IDLE -> no change.
6. Assert rst mid-packet (grant=01000, ptr=3) -> outputs 0 asynchronously. After release, req=11111 -> grant=00001 (ptr reset to 0).
